// File: rtl/ppu_pkg.sv
// Shared PPU definitions: line geometry, shade-to-intensity table, writer state encoding.
// No logic and no latency; constants and a helper function only.
// No flow control; the importing modules decide how the values are used.
package ppu_pkg;

  localparam int LINE_WIDTH = 160;
  localparam int LINE_COUNT = 144;

  // Nibble n holds the 4-bit intensity for shade n: 0->F, 1->A, 2->5, 3->0.
  localparam logic [15:0] SHADE_TABLE = 16'h05AF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PUBLISH = 2'd2,
    HOLD    = 2'd3
  } writerState_t;

  function automatic logic [3:0] shadeIntensity(input logic [1:0] shade);
    return SHADE_TABLE[{shade, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/ppu_line_writer_if.sv
// Pixel stream into the line writer and the published line out of it.
// Ports: frameStart/lineStart/pixelValid/pixelIn (+bgp with PPU_LINE_WRITER_PALETTE_EN) in;
//        LY, LineBuffer0..3, updateBufferSignal, busy, lineError out. Pixels are never stalled.
interface ppu_line_writer_if;
  import ppu_pkg::*;

  logic                  frameStart;
  logic                  lineStart;
  logic                  pixelValid;
  logic [1:0]            pixelIn;
`ifdef PPU_LINE_WRITER_PALETTE_EN
  logic [7:0]            bgp;
`endif
  logic [7:0]            LY;
  logic [LINE_WIDTH-1:0] LineBuffer0;
  logic [LINE_WIDTH-1:0] LineBuffer1;
  logic [LINE_WIDTH-1:0] LineBuffer2;
  logic [LINE_WIDTH-1:0] LineBuffer3;
  logic                  updateBufferSignal;
  logic                  busy;
  logic                  lineError;

  // master: the pixel source / buffer consumer side.
  modport master (
    output frameStart, lineStart, pixelValid, pixelIn,
`ifdef PPU_LINE_WRITER_PALETTE_EN
    output bgp,
`endif
    input  LY, LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3,
    input  updateBufferSignal, busy, lineError
  );

  // slave: the line writer itself.
  modport slave (
    input  frameStart, lineStart, pixelValid, pixelIn,
`ifdef PPU_LINE_WRITER_PALETTE_EN
    input  bgp,
`endif
    output LY, LineBuffer0, LineBuffer1, LineBuffer2, LineBuffer3,
    output updateBufferSignal, busy, lineError
  );

endinterface

// File: rtl/ppu_shade_map.sv
// Maps a 2-bit colour index to a 4-bit intensity, optionally through the BGP palette.
// Purely combinational, zero latency. No flow control.
// Ports: pixelIn, bgp (only with PPU_LINE_WRITER_PALETTE_EN) -> intensity.
module ppu_shade_map
  import ppu_pkg::*;
(
  input  logic [1:0] pixelIn,
`ifdef PPU_LINE_WRITER_PALETTE_EN
  input  logic [7:0] bgp,
`endif
  output logic [3:0] intensity
);

  logic [1:0] shade;

  always_comb begin
`ifdef PPU_LINE_WRITER_PALETTE_EN
    // BGP packs shade for index n in bits [2n+1:2n].
    shade = bgp[{pixelIn, 1'b0} +: 2];
`else
    shade = pixelIn;
`endif
    intensity = shadeIntensity(shade);
  end

endmodule

// File: rtl/ppu_line_writer.sv
// Assembles 160 pixels into four intensity bitplanes and publishes them with LY for HOLD_CYCLES.
// Latency: publish two edges after the 160th pixel (or on the edge after HOLD if one is in progress).
// No backpressure: pixels are always accepted; surplus or orphaned pixels are dropped and flag lineError.
// Ports: pixelClk, nReset (async, active low), bus (ppu_line_writer_if.slave).
// Option: PPU_LINE_WRITER_PALETTE_EN adds bus.bgp and remaps shades through it.
module ppu_line_writer
  import ppu_pkg::*;
#(
  parameter int HOLD_CYCLES = 8   // 4..128
) (
  input logic              pixelClk,
  input logic              nReset,
  ppu_line_writer_if.slave bus
);

  localparam logic [7:0] LAST_X    = 8'(LINE_WIDTH - 1);
  localparam logic [7:0] FULL_X    = 8'(LINE_WIDTH);
  localparam logic [7:0] LAST_LY   = 8'(LINE_COUNT - 1);
  localparam logic [6:0] HOLD_LOAD = 7'(HOLD_CYCLES - 1);

  writerState_t          state, stateNext;
  logic [7:0]            x, nextLY, lyReg;
  logic [6:0]            holdCnt;
  logic                  filling;   // a line is being assembled (may overlap HOLD)
  logic                  pending;   // a complete line waits for its publish edge
  logic                  updReg, errReg;
  logic [LINE_WIDTH-1:0] asm0, asm1, asm2, asm3;
  logic [LINE_WIDTH-1:0] buf0, buf1, buf2, buf3;
  logic [3:0]            intensity;

  logic                  anyStart, writeEn, completing, extraPixel, discard, holdDone;
  logic [7:0]            writeIdx;

  ppu_shade_map uShadeMap (
    .pixelIn  (bus.pixelIn),
`ifdef PPU_LINE_WRITER_PALETTE_EN
    .bgp      (bus.bgp),
`endif
    .intensity(intensity)
  );

  always_comb begin
    anyStart   = bus.frameStart | bus.lineStart;
    // A pixel on the start pulse is pixel 0 of the new line.
    writeEn    = bus.pixelValid & (anyStart | filling);
    writeIdx   = anyStart ? 8'd0 : x;
    completing = writeEn & (writeIdx == LAST_X);
    // x parks at 160 after completion, so this also covers pixels dropped while pending.
    extraPixel = bus.pixelValid & ~anyStart & (x == FULL_X);
    discard    = bus.lineStart & ~bus.frameStart & filling;
    holdDone   = (state == HOLD) && (holdCnt == 7'd0);
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (anyStart) stateNext = FILL;
      FILL:    if (!anyStart && pending) stateNext = PUBLISH;
      PUBLISH: stateNext = HOLD;
      HOLD: begin
        if (holdDone) begin
          if (pending && !anyStart)    stateNext = PUBLISH;
          else if (filling || anyStart) stateNext = FILL;
          else                          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge pixelClk or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      x       <= 8'd0;
      nextLY  <= 8'd0;
      lyReg   <= 8'hFF;
      holdCnt <= 7'd0;
      filling <= 1'b0;
      pending <= 1'b0;
      updReg  <= 1'b0;
      errReg  <= 1'b0;
      asm0    <= '1;
      asm1    <= '1;
      asm2    <= '1;
      asm3    <= '1;
      buf0    <= '1;
      buf1    <= '1;
      buf2    <= '1;
      buf3    <= '1;
    end else begin
      state <= stateNext;

      if (anyStart)     x <= writeEn ? 8'd1 : 8'd0;
      else if (writeEn) x <= x + 8'd1;

      if (writeEn) begin
        asm0[writeIdx] <= intensity[3];
        asm1[writeIdx] <= intensity[2];
        asm2[writeIdx] <= intensity[1];
        asm3[writeIdx] <= intensity[0];
      end

      if (anyStart)        filling <= 1'b1;
      else if (completing) filling <= 1'b0;

      // A new start abandons any unpublished line.
      if (anyStart)                pending <= 1'b0;
      else if (completing)         pending <= 1'b1;
      else if (state == PUBLISH)   pending <= 1'b0;

      // Copy happens before any same-edge write to asm lands, so a new line can start here.
      if (state == PUBLISH) begin
        buf0    <= asm0;
        buf1    <= asm1;
        buf2    <= asm2;
        buf3    <= asm3;
        lyReg   <= nextLY;
        updReg  <= 1'b1;
        holdCnt <= HOLD_LOAD;
      end else if (state == HOLD) begin
        if (holdDone) updReg  <= 1'b0;
        else          holdCnt <= holdCnt - 7'd1;
      end

      if (bus.frameStart)        nextLY <= 8'd0;
      else if (state == PUBLISH) nextLY <= (nextLY == LAST_LY) ? 8'd0 : nextLY + 8'd1;

      if (bus.frameStart)                errReg <= 1'b0;
      else if (extraPixel || discard)    errReg <= 1'b1;
    end
  end

  assign bus.LY                 = lyReg;
  assign bus.LineBuffer0        = buf0;
  assign bus.LineBuffer1        = buf1;
  assign bus.LineBuffer2        = buf2;
  assign bus.LineBuffer3        = buf3;
  assign bus.updateBufferSignal = updReg;
  assign bus.busy               = (state != IDLE) || pending;
  assign bus.lineError          = errReg;

endmodule

// File: tb/tb_ppu_line_writer.sv
// Randomised line stimulus against a transaction-level model of published lines.
// A monitor compares every publish and every idle cycle against the expected line queue.
module tb_ppu_line_writer;
  import ppu_pkg::*;

  localparam int HOLD = 8;

  logic pixelClk = 1'b0;
  logic nReset;
  always #5 pixelClk = ~pixelClk;

  ppu_line_writer_if bus ();

  ppu_line_writer #(.HOLD_CYCLES(HOLD)) dut (
    .pixelClk(pixelClk),
    .nReset  (nReset),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0]   ly;
    logic [159:0] p0;
    logic [159:0] p1;
    logic [159:0] p2;
    logic [159:0] p3;
  } pub_t;

  int   checkCnt = 0;
  int   passCnt  = 0;
  int   lineNum  = 0;
  pub_t expQ[$];
`ifdef PPU_LINE_WRITER_PALETTE_EN
  logic [7:0] palModel = 8'hE4;
`endif

  task automatic checkEq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checkCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Intensity falls by 5 per shade step from white (15).
  function automatic logic [3:0] modelIntensity(input logic [1:0] idx);
    int shade;
`ifdef PPU_LINE_WRITER_PALETTE_EN
    shade = int'((palModel >> (2 * int'(idx))) & 8'h03);
`else
    shade = int'(idx);
`endif
    return 4'(15 - 5 * shade);
  endfunction

  task automatic step();
    @(posedge pixelClk);
    #1;
  endtask

  // mode: 0 random, 1 all index 0, 2 alternating 0/3, 3 all index 2
  task automatic sendLine(input bit useFrame, input int nPix, input int mode);
    pub_t       e;
    int         idx;
    bit         first;
    bit         pushed;
    logic [1:0] pix;
    logic [3:0] inten;
    idx = 0; first = 1'b1; pushed = 1'b0;
    e.p0 = '1; e.p1 = '1; e.p2 = '1; e.p3 = '1; e.ly = 8'd0;
    if (useFrame) lineNum = 0;
    while (first || idx < nPix) begin
      bus.frameStart = first & useFrame;
      bus.lineStart  = first & ~useFrame;
      bus.pixelValid = 1'b0;
      if (idx < nPix && $urandom_range(3) != 0) begin
        case (mode)
          1:       pix = 2'd0;
          2:       pix = (idx % 2 == 1) ? 2'd3 : 2'd0;
          3:       pix = 2'd2;
          default: pix = 2'($urandom_range(3));
        endcase
        bus.pixelValid = 1'b1;
        bus.pixelIn    = pix;
        inten          = modelIntensity(pix);
        e.p0[idx] = inten[3];
        e.p1[idx] = inten[2];
        e.p2[idx] = inten[1];
        e.p3[idx] = inten[0];
        idx++;
      end
      step();
      first = 1'b0;
      if (idx == LINE_WIDTH && !pushed) begin
        e.ly    = 8'(lineNum);
        lineNum = (lineNum + 1) % LINE_COUNT;
        expQ.push_back(e);
        pushed  = 1'b1;
      end
    end
    bus.frameStart = 1'b0;
    bus.lineStart  = 1'b0;
    bus.pixelValid = 1'b0;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((expQ.size() != 0 || bus.updateBufferSignal || bus.busy) && n < 600) begin
      step();
      n++;
    end
    checkEq("drainQueue", 160'(expQ.size()), '0);
    checkEq("drainBusy", 160'(bus.busy), '0);
  endtask

  // Monitor: every cycle the outputs must match the last expected publish.
  initial begin : monitor
    logic         prevUpd;
    int           highCnt;
    logic [7:0]   curLy;
    logic [159:0] cur0, cur1, cur2, cur3;
    pub_t         e;
    prevUpd = 1'b0; highCnt = 0; curLy = 8'hFF;
    cur0 = '1; cur1 = '1; cur2 = '1; cur3 = '1;
    forever begin
      @(posedge pixelClk);
      #2;
      if (!nReset) begin
        prevUpd = 1'b0; highCnt = 0; curLy = 8'hFF;
        cur0 = '1; cur1 = '1; cur2 = '1; cur3 = '1;
      end else begin
        if (bus.updateBufferSignal && !prevUpd) begin
          if (expQ.size() == 0) begin
            checkEq("spuriousPub", 160'(expQ.size()), 160'(1));
          end else begin
            e = expQ.pop_front();
            curLy = e.ly; cur0 = e.p0; cur1 = e.p1; cur2 = e.p2; cur3 = e.p3;
          end
          highCnt = 0;
        end
        if (prevUpd && !bus.updateBufferSignal) checkEq("holdLen", 160'(highCnt), 160'(HOLD));
        if (bus.updateBufferSignal) highCnt++;
        checkEq("ly", 160'(bus.LY), 160'(curLy));
        checkEq("buf0", bus.LineBuffer0, cur0);
        checkEq("buf1", bus.LineBuffer1, cur1);
        checkEq("buf2", bus.LineBuffer2, cur2);
        checkEq("buf3", bus.LineBuffer3, cur3);
        prevUpd = bus.updateBufferSignal;
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int n;
    nReset = 1'b1;
    bus.frameStart = 1'b0;
    bus.lineStart  = 1'b0;
    bus.pixelValid = 1'b0;
    bus.pixelIn    = 2'd0;
`ifdef PPU_LINE_WRITER_PALETTE_EN
    bus.bgp = palModel;
`endif
    #2 nReset = 1'b0;
    repeat (3) @(posedge pixelClk);
    #1;
    checkEq("rstLy",   160'(bus.LY), 160'(8'hFF));
    checkEq("rstBuf0", bus.LineBuffer0, '1);
    checkEq("rstBuf3", bus.LineBuffer3, '1);
    checkEq("rstUpd",  160'(bus.updateBufferSignal), '0);
    checkEq("rstBusy", 160'(bus.busy), '0);
    checkEq("rstErr",  160'(bus.lineError), '0);
    nReset = 1'b1;
    step(); step();

    // First line of a frame, all index 0: white, LY 0.
    sendLine(1'b1, LINE_WIDTH, 1);
    waitIdle();
    checkEq("whiteLy",   160'(bus.LY), '0);
    checkEq("whiteBuf2", bus.LineBuffer2, '1);

    // Alternating 0/3: even bits set in every plane.
    sendLine(1'b0, LINE_WIDTH, 2);
    waitIdle();
    checkEq("altLy",   160'(bus.LY), 160'(1));
    checkEq("altBuf0", bus.LineBuffer0, {40{4'h5}});
    checkEq("altBuf3", bus.LineBuffer3, {40{4'h5}});

    // Random lines up to LY 143, then wrap to 0; next line overlaps the HOLD window.
    for (int i = 0; i < 143; i++) begin
      sendLine(1'b0, LINE_WIDTH, 0);
      repeat ($urandom_range(10, 1)) step();
    end
    waitIdle();
    checkEq("wrapLy",  160'(bus.LY), '0);
    checkEq("wrapErr", 160'(bus.lineError), '0);

    // Five lines then frameStart: LY returns to 0.
    for (int i = 0; i < 5; i++) begin
      sendLine(1'b0, LINE_WIDTH, 0);
      repeat ($urandom_range(4, 1)) step();
    end
    sendLine(1'b1, LINE_WIDTH, 0);
    waitIdle();
    checkEq("frameLy", 160'(bus.LY), '0);

    // Short line abandoned by a new lineStart.
    sendLine(1'b0, 100, 0);
    checkEq("preErr", 160'(bus.lineError), '0);
    sendLine(1'b0, LINE_WIDTH, 0);
    waitIdle();
    checkEq("discardErr", 160'(bus.lineError), 160'(1));
    checkEq("discardLy",  160'(bus.LY), 160'(1));
    sendLine(1'b1, LINE_WIDTH, 0);
    waitIdle();
    checkEq("frameClrErr", 160'(bus.lineError), '0);
    bus.pixelValid = 1'b1;
    bus.pixelIn    = 2'($urandom_range(3));
    step();
    bus.pixelValid = 1'b0;
    step();
    checkEq("extraPixErr", 160'(bus.lineError), 160'(1));

    // Reset in the middle of HOLD.
    sendLine(1'b0, LINE_WIDTH, 0);
    n = 0;
    while (!bus.updateBufferSignal && n < 400) begin
      step();
      n++;
    end
    checkEq("pubSeen", 160'(bus.updateBufferSignal), 160'(1));
    repeat (3) step();
    nReset = 1'b0;
    #1;
    checkEq("holdRstUpd",  160'(bus.updateBufferSignal), '0);
    checkEq("holdRstLy",   160'(bus.LY), 160'(8'hFF));
    checkEq("holdRstBusy", 160'(bus.busy), '0);
    checkEq("holdRstBuf1", bus.LineBuffer1, '1);
    lineNum = 0;
    expQ.delete();
    step(); step();
    nReset = 1'b1;
    repeat (3) step();
    sendLine(1'b0, LINE_WIDTH, 0);
    waitIdle();
    checkEq("postRstLy", 160'(bus.LY), '0);

`ifdef PPU_LINE_WRITER_PALETTE_EN
    // Palette remap of index 2: identity palette, then a reversed one.
    palModel = 8'hE4;
    bus.bgp  = palModel;
    sendLine(1'b0, LINE_WIDTH, 3);
    waitIdle();
    checkEq("palE4Buf0", bus.LineBuffer0, '0);
    checkEq("palE4Buf1", bus.LineBuffer1, '1);
    palModel = 8'h1B;
    bus.bgp  = palModel;
    sendLine(1'b0, LINE_WIDTH, 3);
    waitIdle();
    checkEq("pal1BBuf0", bus.LineBuffer0, '1);
    checkEq("pal1BBuf1", bus.LineBuffer1, '0);
`endif

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
